// File: rtl/keys_paddle_pkg.sv
// keys_paddle_pkg: shared key indices, default sync level and saturating position step.
package keys_paddle_pkg;
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;
  localparam logic SYNC_ACT_DEF = 1'b1;
  // dir = {increment, decrement}; both or neither holds the position
  function automatic logic [31:0] sat_step(input logic [31:0] pos, input logic [31:0] step,
                                           input logic [1:0] dir, input logic [31:0] lo,
                                           input logic [31:0] hi);
    logic [32:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (dir == 2'b10) return (sum > {1'b0, hi}) ? hi : sum[31:0];
    if (dir == 2'b01) return (pos < lo + step) ? lo : pos - step;
    return pos;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer followed by a stable-count debouncer for one key.
module key_debounce #(
  parameter int DEB_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q + 1'b1;
    if (sync_q[1] == stable_q) cnt_d = '0;
    else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], din};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
  assign dout = stable_q;
endmodule

// File: rtl/keys_paddle_emu.sv
// keys_paddle_emu: debounced keys move two positions per frame; each paddle line rises
// once the scanline count reaches its position.
module keys_paddle_emu
  import keys_paddle_pkg::*;
#(
  parameter int   DEB_CYCLES = 65536,
  parameter int   POS_W      = 9,
  parameter int   POS_MIN    = 0,
  parameter int   POS_MAX    = 240,
  parameter int   POS_INIT   = 120,
  parameter int   STEP       = 2,
  parameter logic SYNC_ACT   = SYNC_ACT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       keys,
  input  logic             hsync,
  input  logic             vsync,
  output logic             hpaddle,
  output logic             vpaddle,
  output logic [POS_W-1:0] pos_h,
  output logic [POS_W-1:0] pos_v
);
  logic [3:0]       key_db;
  logic             hsync_q, vsync_q, frame_tick, line_tick;
  logic             hpaddle_q, hpaddle_d, vpaddle_q, vpaddle_d;
  logic [POS_W-1:0] line_cnt_q, line_cnt_d, pos_h_q, pos_h_d, pos_v_q, pos_v_d;
  for (genvar k = 0; k < 4; k++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk), .reset(reset), .din(keys[k]), .dout(key_db[k])
    );
  end
  always_comb begin
    frame_tick = (vsync == SYNC_ACT) && (vsync_q != SYNC_ACT);
    line_tick  = (hsync == SYNC_ACT) && (hsync_q != SYNC_ACT);
    line_cnt_d = frame_tick ? '0 :
                 (line_tick && line_cnt_q != '1) ? line_cnt_q + 1'b1 : line_cnt_q;
    pos_h_d    = frame_tick ? POS_W'(sat_step(32'(pos_h_q), 32'(STEP),
                   {key_db[KEY_RIGHT], key_db[KEY_LEFT]}, 32'(POS_MIN), 32'(POS_MAX))) : pos_h_q;
    pos_v_d    = frame_tick ? POS_W'(sat_step(32'(pos_v_q), 32'(STEP),
                   {key_db[KEY_DOWN], key_db[KEY_UP]}, 32'(POS_MIN), 32'(POS_MAX))) : pos_v_q;
    hpaddle_d  = (vsync != SYNC_ACT) && (line_cnt_q >= pos_h_q);
    vpaddle_d  = (vsync != SYNC_ACT) && (line_cnt_q >= pos_v_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q    <= ~SYNC_ACT;
      vsync_q    <= ~SYNC_ACT;
      line_cnt_q <= '0;
      pos_h_q    <= POS_W'(POS_INIT);
      pos_v_q    <= POS_W'(POS_INIT);
      hpaddle_q  <= 1'b0;
      vpaddle_q  <= 1'b0;
    end else begin
      hsync_q    <= hsync;
      vsync_q    <= vsync;
      line_cnt_q <= line_cnt_d;
      pos_h_q    <= pos_h_d;
      pos_v_q    <= pos_v_d;
      hpaddle_q  <= hpaddle_d;
      vpaddle_q  <= vpaddle_d;
    end
  end
  assign hpaddle = hpaddle_q;
  assign vpaddle = vpaddle_q;
  assign pos_h   = pos_h_q;
  assign pos_v   = pos_v_q;
endmodule

// File: tb/tb_keys_paddle_emu.sv
// tb_keys_paddle_emu: directed checks of debounce, saturation, paddle timing and reset,
// on an active-high-sync instance and an inverted-sync twin driven identically.
module tb_keys_paddle_emu;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keys = '0;
  logic       hsync = 1'b0, vsync = 1'b0;
  logic       hp, vp, hp2, vp2;
  logic [8:0] pos_h, pos_v, pos_h2, pos_v2;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  keys_paddle_emu #(.DEB_CYCLES(4), .SYNC_ACT(1'b1)) dut (
    .clk(clk), .reset(reset), .keys(keys), .hsync(hsync), .vsync(vsync),
    .hpaddle(hp), .vpaddle(vp), .pos_h(pos_h), .pos_v(pos_v));
  keys_paddle_emu #(.DEB_CYCLES(4), .SYNC_ACT(1'b0)) dut2 (
    .clk(clk), .reset(reset), .keys(keys), .hsync(~hsync), .vsync(~vsync),
    .hpaddle(hp2), .vpaddle(vp2), .pos_h(pos_h2), .pos_v(pos_v2));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic line();
    hsync = 1'b1; tick(1); hsync = 1'b0; tick(3);
  endtask
  task automatic frame();
    vsync = 1'b1; tick(2); vsync = 1'b0;
    repeat (10) line();
  endtask
  task automatic press(input logic [3:0] k);
    keys = k; tick(8);
  endtask

  task automatic test_reset;
    tick(2);
    n_chk++; if ({hp, vp, hp2, vp2} !== 4'b0) begin n_fail++; $display("FAIL reset_paddles: got %b want 0000", {hp, vp, hp2, vp2}); end
    n_chk++; if (pos_h !== 9'd120 || pos_v !== 9'd120) begin n_fail++; $display("FAIL reset_pos: got h=%0d v=%0d want 120", pos_h, pos_v); end
    reset = 1'b0;
    tick(2);
    frame();
    n_chk++; if (pos_h !== 9'd120 || pos_h2 !== 9'd120) begin n_fail++; $display("FAIL idle_frame: got h=%0d h2=%0d want 120", pos_h, pos_h2); end
  endtask

  task automatic test_debounce;
    keys[1] = 1'b1; tick(3); keys = '0; tick(10);
    frame();
    n_chk++; if (pos_h !== 9'd120) begin n_fail++; $display("FAIL glitch: got pos_h=%0d want 120", pos_h); end
    keys[1] = 1'b1; tick(7);
    vsync = 1'b1; tick(3); keys = '0; vsync = 1'b0; tick(10);
    n_chk++; if (pos_h !== 9'd122 || pos_h2 !== 9'd122) begin n_fail++; $display("FAIL held_right: got h=%0d h2=%0d want 122", pos_h, pos_h2); end
    frame();
    n_chk++; if (pos_h !== 9'd122) begin n_fail++; $display("FAIL release: got pos_h=%0d want 122", pos_h); end
  endtask

  task automatic test_both_up;
    press(4'b0011);
    repeat (5) frame();
    n_chk++; if (pos_h !== 9'd122 || pos_v !== 9'd120) begin n_fail++; $display("FAIL both_lr: got h=%0d v=%0d want 122/120", pos_h, pos_v); end
    press(4'b0100);
    repeat (3) frame();
    n_chk++; if (pos_v !== 9'd114 || pos_v2 !== 9'd114) begin n_fail++; $display("FAIL up3: got v=%0d v2=%0d want 114", pos_v, pos_v2); end
    press(4'b0000);
  endtask

  task automatic test_saturation;
    press(4'b0010);
    repeat (70) frame();
    n_chk++; if (pos_h !== 9'd240) begin n_fail++; $display("FAIL sat_max: got pos_h=%0d want 240", pos_h); end
    press(4'b0001);
    repeat (115) frame();
    n_chk++; if (pos_h !== 9'd10) begin n_fail++; $display("FAIL left_to_10: got pos_h=%0d want 10", pos_h); end
    for (int f = 0; f < 130; f++) begin
      frame();
      n_chk++; if (pos_h > 9'd10) begin n_fail++; $display("FAIL no_wrap: frame %0d got pos_h=%0d want <=10", f, pos_h); end
    end
    n_chk++; if (pos_h !== 9'd0 || pos_h2 !== 9'd0) begin n_fail++; $display("FAIL sat_min: got h=%0d h2=%0d want 0", pos_h, pos_h2); end
  endtask

  task automatic test_paddle;
    logic e;
    press(4'b0100);
    repeat (57) frame();
    press(4'b0010);
    repeat (2) frame();
    press(4'b0000);
    n_chk++; if (pos_h !== 9'd4 || pos_v !== 9'd0) begin n_fail++; $display("FAIL paddle_setup: got h=%0d v=%0d want 4/0", pos_h, pos_v); end
    vsync = 1'b1; tick(2);
    n_chk++; if ({hp, vp, hp2, vp2} !== 4'b0) begin n_fail++; $display("FAIL vsync_force: got %b want 0000", {hp, vp, hp2, vp2}); end
    vsync = 1'b0; tick(1);
    n_chk++; if ({hp, vp, hp2, vp2} !== 4'b0101) begin n_fail++; $display("FAIL vpad_rise: got %b want 0101", {hp, vp, hp2, vp2}); end
    for (int i = 1; i <= 10; i++) begin
      hsync = 1'b1; tick(1);
      e = (i >= 5);
      n_chk++; if (hp !== e || hp2 !== e) begin n_fail++; $display("FAIL hpad_edge line %0d: got %b/%b want %b", i, hp, hp2, e); end
      hsync = 1'b0; tick(1);
      e = (i >= 4);
      n_chk++; if (hp !== e || hp2 !== e) begin n_fail++; $display("FAIL hpad_after line %0d: got %b/%b want %b", i, hp, hp2, e); end
      tick(2);
    end
    vsync = 1'b1; tick(1);
    n_chk++; if ({hp, vp, hp2, vp2} !== 4'b0) begin n_fail++; $display("FAIL vsync_drop: got %b want 0000", {hp, vp, hp2, vp2}); end
    tick(1); vsync = 1'b0; tick(1);
  endtask

  task automatic test_simultaneous;
    repeat (3) line();
    n_chk++; if (dut.line_cnt_q !== 9'd3 || dut2.line_cnt_q !== 9'd3) begin n_fail++; $display("FAIL line_cnt3: got %0d/%0d want 3", dut.line_cnt_q, dut2.line_cnt_q); end
    vsync = 1'b1; hsync = 1'b1; tick(1);
    n_chk++; if (dut.line_cnt_q !== 9'd0 || dut2.line_cnt_q !== 9'd0) begin n_fail++; $display("FAIL simul_edge: got %0d/%0d want 0", dut.line_cnt_q, dut2.line_cnt_q); end
    hsync = 1'b0; tick(1); vsync = 1'b0; tick(1);
    line();
    n_chk++; if (dut.line_cnt_q !== 9'd1 || dut2.line_cnt_q !== 9'd1) begin n_fail++; $display("FAIL first_line: got %0d/%0d want 1", dut.line_cnt_q, dut2.line_cnt_q); end
  endtask

  task automatic test_reset_mid;
    vsync = 1'b1; tick(2); vsync = 1'b0;
    repeat (6) line();
    n_chk++; if ({hp, vp} !== 2'b11) begin n_fail++; $display("FAIL pre_reset: got %b want 11", {hp, vp}); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if ({hp, vp, hp2, vp2} !== 4'b0) begin n_fail++; $display("FAIL async_reset_pad: got %b want 0000", {hp, vp, hp2, vp2}); end
    n_chk++; if (pos_h !== 9'd120 || pos_v !== 9'd120 || pos_h2 !== 9'd120) begin n_fail++; $display("FAIL async_reset_pos: got h=%0d v=%0d h2=%0d want 120", pos_h, pos_v, pos_h2); end
    @(negedge clk); reset = 1'b0;
    repeat (3) line();
    n_chk++; if ({hp, vp, hp2, vp2} !== 4'b0) begin n_fail++; $display("FAIL post_reset_hold: got %b want 0000", {hp, vp, hp2, vp2}); end
    frame();
    n_chk++; if (pos_h !== 9'd120 || pos_v !== 9'd120) begin n_fail++; $display("FAIL post_reset_frame: got h=%0d v=%0d want 120", pos_h, pos_v); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_both_up();
    test_saturation();
    test_paddle();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
